npu_param_loader: RTL and testbench
===================================

NPU_PARAM_LOADER -- requirements
Module: npu_param_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the signed word width of each weight and bias.
REQ-002 SHALL have parameter IN_N, default 4, giving the number of layer inputs (weights per neuron).
REQ-003 SHALL have parameter OUT_N, default 4, giving the number of layer neurons (bias count).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port clk  input  1  system clock; all state updates on the rising edge.
REQ-006 Port rst  input  1  synchronous, active-high reset.
REQ-007 Port start  input  1  one-cycle request to begin a load; honoured in IDLE only.
REQ-008 Port s_valid  input  1  stream word valid.
REQ-009 Port s_ready  output  1  stream word accept.
REQ-010 Port s_data  input  DATA_WIDTH  signed stream word.
REQ-011 Port s_last  input  1  marks the final word of a load.
REQ-012 Port weights  output  IN_N*OUT_N*DATA_WIDTH  active packed signed weights.
REQ-013 Port biases  output  OUT_N*DATA_WIDTH  active packed signed biases.
REQ-014 Port params_valid  output  1  high once any load has committed.
REQ-015 Port load_done  output  1  one-cycle pulse on commit.
REQ-016 Port load_err  output  1  one-cycle pulse on a framing error.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD_W, LOAD_B and COMMIT.
REQ-018 SHALL accept a word only when s_valid and s_ready are both high in the same cycle.
REQ-019 SHALL drive s_ready high in LOAD_W and LOAD_B, and low in IDLE and COMMIT.
REQ-020 In IDLE, start SHALL move to LOAD_W and clear the word counter; start in any other state SHALL be ignored.
REQ-021 Load order SHALL be IN_N*OUT_N weights, then OUT_N biases.
REQ-022 Weight word k (k = o*IN_N + i) SHALL land in shadow bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-023 Bias word b SHALL land in shadow bits [b*DATA_WIDTH +: DATA_WIDTH].
REQ-024 SHALL move LOAD_W to LOAD_B on acceptance of weight word IN_N*OUT_N-1, resetting the counter.
REQ-025 Accepting bias word OUT_N-1 with s_last high SHALL move to COMMIT.
REQ-026 In COMMIT, SHALL copy shadow to weights/biases, pulse load_done, set params_valid, then return to IDLE next cycle.
REQ-027 Latency: weights, biases and load_done SHALL change exactly one cycle after the final accepted word.
REQ-028 weights/biases SHALL hold stable at all times except the COMMIT update.
REQ-029 s_last high on any accepted word other than the final bias SHALL pulse load_err the next cycle, return to IDLE and discard the shadow, leaving active outputs unchanged.
REQ-030 The final bias accepted with s_last low SHALL pulse load_err the next cycle, return to IDLE and discard the shadow, leaving active outputs unchanged.
REQ-031 s_valid low SHALL stall without counter change; words presented in IDLE/COMMIT SHALL be ignored.
REQ-032 load_done and load_err SHALL never be asserted in the same cycle.

Reset
REQ-033 On rst, SHALL set state IDLE, counter 0, and weights, biases, shadow, params_valid, load_done and load_err all to 0, with s_ready low.
REQ-034 rst mid-load SHALL abort the load with no load_done/load_err pulse; rst SHALL take priority over start.

Verification (IN_N=2, OUT_N=2, DATA_WIDTH=8)
REQ-035 rst, then start + words 1,2,3,4,-1,-2 (last on -2) -> load_done at one cycle after -2; weights=0x04030201; biases=0xFEFF; params_valid=1.
REQ-036 Same load with s_valid toggled every other cycle -> identical outputs; load_done one cycle after final accept.
REQ-037 Load A committed, then load B with s_last on word 3 -> load_err pulse; outputs still equal A; s_ready low; next start succeeds.
REQ-038 Load with s_last low on final bias -> load_err, outputs unchanged, state IDLE.
REQ-039 start during LOAD_W -> ignored, counter continues; words with s_valid in IDLE -> s_ready=0, nothing captured.
REQ-040 rst asserted after word 3 -> all outputs 0, no pulses; fresh load then commits correctly.

Source files
------------

// File: rtl/npu_param_loader.sv
// Streams one layer's weights and biases into a shadow buffer and publishes them
// atomically on a well-framed load. Framing errors drop the shadow and leave active parameters.
module npu_param_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_N       = 4,
    parameter int OUT_N      = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [DATA_WIDTH-1:0]            s_data,
    input  logic                             s_last,
    output logic [IN_N*OUT_N*DATA_WIDTH-1:0] weights,
    output logic [OUT_N*DATA_WIDTH-1:0]      biases,
    output logic                             params_valid,
    output logic                             load_done,
    output logic                             load_err
);

    localparam int NW    = IN_N * OUT_N;
    localparam int CNT_N = (NW > OUT_N) ? NW : OUT_N;
    localparam int CW    = $clog2(CNT_N + 1);
    localparam logic [CW-1:0] LAST_W = CW'(NW - 1);
    localparam logic [CW-1:0] LAST_B = CW'(OUT_N - 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, COMMIT} state_t;

    state_t                          r_state;
    logic [CW-1:0]                   r_cnt;
    logic [NW*DATA_WIDTH-1:0]        r_shadow_w;
    logic [OUT_N*DATA_WIDTH-1:0]     r_shadow_b;
    logic [NW*DATA_WIDTH-1:0]        r_weights;
    logic [OUT_N*DATA_WIDTH-1:0]     r_biases;
    logic                            r_params_valid;
    logic                            r_load_done;
    logic                            r_load_err;
    logic                            w_accept;
    logic [OUT_N*DATA_WIDTH-1:0]     w_bias_final;

    assign s_ready      = (r_state == LOAD_W) || (r_state == LOAD_B);
    assign w_accept     = s_valid && s_ready;
    assign weights      = r_weights;
    assign biases       = r_biases;
    assign params_valid = r_params_valid;
    assign load_done    = r_load_done;
    assign load_err     = r_load_err;

    // Shadow biases with the word currently on the bus merged in as the final bias.
    always_comb begin
        w_bias_final = r_shadow_b;
        w_bias_final[(OUT_N-1)*DATA_WIDTH +: DATA_WIDTH] = s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_shadow_w     <= '0;
            r_shadow_b     <= '0;
            r_weights      <= '0;
            r_biases       <= '0;
            r_params_valid <= 1'b0;
            r_load_done    <= 1'b0;
            r_load_err     <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD_W;
                        r_cnt   <= '0;
                    end
                end
                LOAD_W: begin
                    if (w_accept) begin
                        if (s_last) begin
                            r_load_err <= 1'b1;
                            r_state    <= IDLE;
                            r_cnt      <= '0;
                            r_shadow_w <= '0;
                            r_shadow_b <= '0;
                        end else begin
                            r_shadow_w[r_cnt*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                            if (r_cnt == LAST_W) begin
                                r_state <= LOAD_B;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                end
                LOAD_B: begin
                    if (w_accept) begin
                        if ((r_cnt == LAST_B) && s_last) begin
                            // Publish on the accepting edge so outputs move one cycle after it;
                            // COMMIT is the cycle in which load_done is visible.
                            r_weights      <= r_shadow_w;
                            r_biases       <= w_bias_final;
                            r_shadow_b     <= w_bias_final;
                            r_params_valid <= 1'b1;
                            r_load_done    <= 1'b1;
                            r_state        <= COMMIT;
                            r_cnt          <= '0;
                        end else if ((r_cnt == LAST_B) || s_last) begin
                            r_load_err <= 1'b1;
                            r_state    <= IDLE;
                            r_cnt      <= '0;
                            r_shadow_w <= '0;
                            r_shadow_b <= '0;
                        end else begin
                            r_shadow_b[r_cnt*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npu_param_loader.sv
// Scoreboard bench for npu_param_loader (IN_N=2, OUT_N=2, DATA_WIDTH=8): stimulus queues
// expected done/err pulses, a negedge monitor pops and compares them and tracks active outputs.
module tb_npu_param_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic [31:0] weights;
    logic [15:0] biases;
    logic        params_valid;
    logic        load_done;
    logic        load_err;

    npu_param_loader #(
        .DATA_WIDTH(8),
        .IN_N      (2),
        .OUT_N     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .weights     (weights),
        .biases      (biases),
        .params_valid(params_valid),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    typedef struct {
        bit          is_done;
        int          cyc;
        logic [31:0] w;
        logic [15:0] b;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          mon_en = 0;
    logic [31:0] m_w = '0;
    logic [15:0] m_b = '0;
    logic        m_pv = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pulse checking against the scoreboard plus continuous active-output tracking.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            if (load_done && load_err) chk("done_err_overlap", 1, 0);
            if (load_done || load_err) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {load_done, load_err}, 0);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind", {load_done, load_err}, e.is_done ? 2'b10 : 2'b01);
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("pulse_weights", weights, e.w);
                    chk("pulse_biases", biases, e.b);
                end
            end
            if (q.size() > 0 && cyc > q[0].cyc) begin
                e = q.pop_front();
                chk("missed_pulse_cycle", cyc, e.cyc);
            end
            chk("active_weights", weights, m_w);
            chk("active_biases", biases, m_b);
            chk("params_valid", params_valid, m_pv);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // last_at: index of the word carrying s_last (-1 = none); sending stops there when < 5.
    task automatic run_load(input logic [7:0] words[6], input int last_at, input bit gap,
                            input bit mid_start);
        exp_t e;
        int   n;
        n = (last_at >= 0 && last_at < 5) ? last_at + 1 : 6;
        do_start();
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = words[i];
            s_last  = (i == last_at);
            start   = mid_start && (i == 1);
            tick();
            s_valid = 1'b0;
            s_last  = 1'b0;
            start   = 1'b0;
            if (gap && i < n - 1) begin
                s_data = 8'hAA;
                tick();
            end
        end
        e.cyc = cyc;
        e.is_done = (last_at == 5);
        if (e.is_done) begin
            m_w  = {words[3], words[2], words[1], words[0]};
            m_b  = {words[5], words[4]};
            m_pv = 1'b1;
        end
        e.w = m_w;
        e.b = m_b;
        q.push_back(e);
        chk("s_ready_after_load", s_ready, 0);
    endtask

    logic [7:0] la[6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFE};
    logic [7:0] lb[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] lc[6] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h7F, 8'h80};
    logic [7:0] ld[6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_weights", weights, 0);
        chk("rst_biases", biases, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_pulses", {load_done, load_err}, 0);
        tick();

        // Basic load
        run_load(la, 5, 1'b0, 1'b0);
        chk("load_done_now", load_done, 1);
        chk("spec_weights", weights, 32'h04030201);
        chk("spec_biases", biases, 16'hFEFF);
        repeat (2) tick();

        // Same load with s_valid toggling
        run_load(la, 5, 1'b1, 1'b0);
        repeat (2) tick();

        // s_last on word 3 -> error, outputs unchanged
        run_load(lb, 2, 1'b0, 1'b0);
        chk("err_now", load_err, 1);
        chk("err_keeps_w", weights, 32'h04030201);
        repeat (2) tick();
        run_load(lc, 5, 1'b0, 1'b0);
        chk("after_err_w", weights, 32'h40302010);
        chk("after_err_b", biases, 16'h807F);
        repeat (2) tick();

        // No s_last on final bias -> error
        run_load(lb, -1, 1'b0, 1'b0);
        chk("err_nolast", load_err, 1);
        tick();
        chk("idle_after_err", s_ready, 0);
        tick();

        // Words in IDLE ignored
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 8'h5A; s_last = i[0];
            tick();
            chk("idle_s_ready", s_ready, 0);
        end
        s_valid = 1'b0; s_last = 1'b0;
        tick();

        // start during LOAD_W ignored
        run_load(ld, 5, 1'b0, 1'b1);
        repeat (2) tick();

        // rst mid-load after word 3
        do_start();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = lb[i]; s_last = 1'b0;
            tick();
        end
        s_valid = 1'b0;
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        m_w = '0; m_b = '0; m_pv = 1'b0;
        chk("midrst_weights", weights, 0);
        chk("midrst_s_ready", s_ready, 0);
        repeat (3) tick();
        run_load(la, 5, 1'b0, 1'b0);
        chk("fresh_weights", weights, 32'h04030201);
        repeat (4) tick();

        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
